adrv9009_rhb1_dec2: RTL
=======================

ADRV9009_RHB1_DEC2 -- requirements
Module: adrv9009_rhb1_dec2

Interface
REQ-001 The block SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-002 The block SHALL have port reset  input  1  reset; reset is synchronous and active-high.
REQ-003 The block SHALL have port in_valid  input  1  in_data accepted this cycle.
REQ-004 The block SHALL have port in_data  input  16  signed Q1.15 sample at 2x output rate.
REQ-005 The block SHALL have port out_valid  output  1  out_data is new this cycle; feeds the downstream RFIR input.
REQ-006 The block SHALL have port out_data  output  16  signed Q1.15 decimated sample.

Function
REQ-007 The block SHALL be an 11-tap half-band FIR that decimates by 2: h0=h10=256, h2=h8=-1536, h4=h6=9472, h5=16384, all odd taps except h5 = 0; DC gain is exactly 1.0.
REQ-008 The delay line SHALL be x[n]..x[n-10], 16-bit, and SHALL shift only in cycles where in_valid=1.
REQ-009 A phase bit SHALL toggle on every accepted sample; an output SHALL be computed for each accepted sample taken while phase=1 (2nd, 4th, ... sample after reset).
REQ-010 The output SHALL be y = sum h[k]*x[n-k], where x[n] is the phase-1 sample just accepted.
REQ-011 The pipeline SHALL have 3 stages: S1 symmetric pre-add (17-bit); S2 three 17x16 multiplies plus h5*x[n-5] (33-bit); S3 36-bit sum, round, saturate, and register.
REQ-012 out_valid SHALL pulse high for exactly 1 cycle, 3 cycles after the in_valid cycle that completes a pair; latency SHALL be fixed and independent of in_valid gaps.
REQ-013 Scaling SHALL be y >> 15, followed by saturation to [-32768, 32767].
REQ-014 out_data SHALL hold its last value while out_valid=0.
REQ-015 The block SHALL apply no back-pressure: every in_valid sample is consumed, and in_valid is allowed every cycle.
REQ-016 in_valid=0 SHALL freeze the delay line and the phase bit; pipeline stages already in flight SHALL still complete.

Reset
REQ-017 Reset SHALL set out_valid=0, out_data=0, phase=0, all delay-line taps=0, and all pipeline valid bits=0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight results: no out_valid in the cycle after reset, and no out_valid for any sample accepted before reset.
REQ-019 in_valid SHALL be ignored in any cycle where reset=1.

Configuration
REQ-020 With macro ADRV9009_RHB1_ROUND_EN defined, S3 SHALL add 2^14 before the shift (round half up).
REQ-021 Without ADRV9009_RHB1_ROUND_EN, S3 SHALL truncate (floor toward -inf); latency SHALL be identical in both builds.

Structure
REQ-022 Package adrv9009_rx_pkg SHALL hold the coefficient constants (RHB1_H0/H2/H4/H5), SAMPLE_W=16, COEFF_W=16, ACC_W=36, and the sample typedef shared with the RFIR.
REQ-023 The round-and-saturate logic SHALL be in sub-module adrv9009_rnd_sat16 (36-bit in, 16-bit out, honours the macro), reusable by the RFIR output stage.

Verification
REQ-024 Impulse test: in_valid=1 every cycle, samples 0, -32768, then zeros -> outputs -256, 1536, -9472, -9472, 1536, -256, then 0; identical in both builds.
REQ-025 DC test: constant 1000 every cycle -> from the 6th output onward out_data=1000, one out_valid every 2 cycles, each 3 cycles after the pair-completing sample.
REQ-026 Rounding test: samples 0, 100, then zeros -> first output 1 with ADRV9009_RHB1_ROUND_EN and 0 without (25600/32768).
REQ-027 Saturation test: window with +32767 at taps 4,5,6 and -32768 at taps 2,8 -> out_data=32767, with no wrap.
REQ-028 Gap and reset test: DC 1000 with in_valid every 3rd cycle -> same values, out_valid every 6 cycles. Then reset with 2 results in flight -> no out_valid; after reset, the first output appears 3 cycles after the 2nd accepted sample and computes from zero history.

Source files
------------

// File: rtl/adrv9009_rx_pkg.sv
// Shared constants and types for the ADRV9009 RX decimation chain (RHB1, RFIR).
// Build option: define ADRV9009_RHB1_ROUND_EN for round-half-up output scaling
// (consumed by adrv9009_rnd_sat16); default build truncates.
package adrv9009_rx_pkg;

    localparam int SAMPLE_W = 16;
    localparam int COEFF_W  = 16;
    localparam int ACC_W    = 36;
    // Symmetric pre-add needs one guard bit; 17x16 product needs 33 bits.
    localparam int PRE_W    = SAMPLE_W + 1;
    localparam int PROD_W   = PRE_W + COEFF_W;
    // Output scaling: Q1.15 coefficients, so drop 15 fractional bits.
    localparam int SHIFT    = 15;

    // RHB1 half-band coefficients (Q1.15); odd taps other than the centre are zero.
    localparam logic signed [COEFF_W-1:0] RHB1_H0 = 16'sd256;
    localparam logic signed [COEFF_W-1:0] RHB1_H2 = -16'sd1536;
    localparam logic signed [COEFF_W-1:0] RHB1_H4 = 16'sd9472;
    localparam logic signed [COEFF_W-1:0] RHB1_H5 = 16'sd16384;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [PRE_W-1:0]    preadd_t;
    typedef logic signed [PROD_W-1:0]   prod_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    // Sign-extending add of two mirrored taps.
    function automatic preadd_t pre_add(input sample_t a, input sample_t b);
        return preadd_t'(a) + preadd_t'(b);
    endfunction

endpackage

// File: rtl/adrv9009_rnd_sat16.sv
// Scale a 36-bit accumulator down by 2^15 and saturate to a 16-bit sample.
// Build option: ADRV9009_RHB1_ROUND_EN adds 2^14 before the shift (round half up);
// otherwise the shift truncates toward -inf. Purely combinational, so both builds
// share the same latency in whichever stage registers the result.
module adrv9009_rnd_sat16
    import adrv9009_rx_pkg::*;
(
    input  logic signed [ACC_W-1:0]    i_acc,
    output logic signed [SAMPLE_W-1:0] o_data
);

    localparam acc_t SAT_MAX = 36'sd32767;
    localparam acc_t SAT_MIN = -36'sd32768;
`ifdef ADRV9009_RHB1_ROUND_EN
    localparam acc_t RND_BIAS = acc_t'(1) <<< (SHIFT - 1);
`endif

    acc_t w_biased;
    acc_t w_shifted;

    // Optional rounding bias, arithmetic shift, then clamp to the sample range.
    always_comb begin
`ifdef ADRV9009_RHB1_ROUND_EN
        w_biased = i_acc + RND_BIAS;
`else
        w_biased = i_acc;
`endif
        w_shifted = w_biased >>> SHIFT;
        if (w_shifted > SAT_MAX) begin
            o_data = sample_t'(SAT_MAX);
        end else if (w_shifted < SAT_MIN) begin
            o_data = sample_t'(SAT_MIN);
        end else begin
            o_data = w_shifted[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/adrv9009_rhb1_dec2.sv
// RHB1: 11-tap half-band FIR with decimate-by-2, 3-stage pipeline.
// Build option: ADRV9009_RHB1_ROUND_EN selects round-half-up in the output stage
// (see adrv9009_rnd_sat16); default build truncates. Latency is identical.
//
// The newest sample x[n] is taken straight from in_data so that the pre-add can
// be registered on the same edge that accepts the pair-completing sample; the
// registered delay line holds x[n-1]..x[n-10]. Output lands 3 cycles later.
module adrv9009_rhb1_dec2
    import adrv9009_rx_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_data,
    output logic                       out_valid,
    output logic signed [SAMPLE_W-1:0] out_data
);

    // Delay line and decimation phase.
    sample_t r_dly [1:10];
    logic    r_phase;

    // Stage 1: symmetric pre-adds and centre tap.
    preadd_t r_s1_p0;
    preadd_t r_s1_p2;
    preadd_t r_s1_p4;
    sample_t r_s1_c;
    logic    r_s1_v;

    // Stage 2: products.
    prod_t   r_s2_m0;
    prod_t   r_s2_m2;
    prod_t   r_s2_m4;
    prod_t   r_s2_m5;
    logic    r_s2_v;

    // Stage 3: registered output.
    sample_t r_out_data;
    logic    r_out_valid;

    logic    w_fire;
    preadd_t w_p0;
    preadd_t w_p2;
    preadd_t w_p4;
    prod_t   w_m0;
    prod_t   w_m2;
    prod_t   w_m4;
    prod_t   w_m5;
    acc_t    w_sum;
    sample_t w_rs;

    // A result is launched for the second sample of every accepted pair.
    assign w_fire = in_valid & r_phase;

    // Delay line shift and phase toggle, frozen when in_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= 10; k++) begin
                r_dly[k] <= '0;
            end
            r_phase <= 1'b0;
        end else if (in_valid) begin
            r_dly[1] <= in_data;
            for (int k = 2; k <= 10; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
            r_phase <= ~r_phase;
        end
    end

    // Pre-add mirrored taps of the window whose newest sample is in_data.
    always_comb begin
        w_p0 = pre_add(in_data, r_dly[10]);
        w_p2 = pre_add(r_dly[2], r_dly[8]);
        w_p4 = pre_add(r_dly[4], r_dly[6]);
    end

    // Stage 1 register; data only loads when a result is launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_v  <= 1'b0;
            r_s1_p0 <= '0;
            r_s1_p2 <= '0;
            r_s1_p4 <= '0;
            r_s1_c  <= '0;
        end else begin
            r_s1_v <= w_fire;
            if (w_fire) begin
                r_s1_p0 <= w_p0;
                r_s1_p2 <= w_p2;
                r_s1_p4 <= w_p4;
                r_s1_c  <= r_dly[5];
            end
        end
    end

    // Coefficient multiplies at full product width.
    always_comb begin
        w_m0 = prod_t'(r_s1_p0) * prod_t'(RHB1_H0);
        w_m2 = prod_t'(r_s1_p2) * prod_t'(RHB1_H2);
        w_m4 = prod_t'(r_s1_p4) * prod_t'(RHB1_H4);
        w_m5 = prod_t'(r_s1_c) * prod_t'(RHB1_H5);
    end

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_v  <= 1'b0;
            r_s2_m0 <= '0;
            r_s2_m2 <= '0;
            r_s2_m4 <= '0;
            r_s2_m5 <= '0;
        end else begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_m0 <= w_m0;
                r_s2_m2 <= w_m2;
                r_s2_m4 <= w_m4;
                r_s2_m5 <= w_m5;
            end
        end
    end

    // Accumulate the four products at accumulator width.
    always_comb begin
        w_sum = acc_t'(r_s2_m0) + acc_t'(r_s2_m2) + acc_t'(r_s2_m4) + acc_t'(r_s2_m5);
    end

    adrv9009_rnd_sat16 u_rnd_sat (
        .i_acc  (w_sum),
        .o_data (w_rs)
    );

    // Output register; data holds between valid pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_s2_v;
            if (r_s2_v) begin
                r_out_data <= w_rs;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
